// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP16 multiplier among
// NUM_REQ requesters; results are tagged with the requester index and pipelined.
module fp16_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_result,
  output logic                   busy,
  output logic [31:0]            op_count
);

  // Truncating FP16 multiply: no rounding and no special-value handling.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [11:0] ph;
    logic [4:0]  e;
    logic [9:0]  m;
    p  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    ph = 12'(p >> 10);
    e  = a[14:10] + b[14:10] - 5'd15 + 5'(ph[11]);
    m  = ph[11] ? ph[10:1] : ph[9:0];
    return {a[15] ^ b[15], e, m};
  endfunction

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            xfer;

  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  assign xfer      = rst_n & en & grant_any;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  // Stage p0: operand capture
  logic [15:0]     a_p0;
  logic [15:0]     b_p0;
  logic [ID_W-1:0] id_p0;
  logic            vld_p0;
  logic [15:0]     prod_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      vld_p0   <= 1'b0;
      id_p0    <= '0;
      op_count <= '0;
    end else begin
      vld_p0 <= xfer;
      if (xfer) begin
        ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        id_p0    <= grant_idx;
        op_count <= op_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      a_p0 <= req_a[{grant_idx, 4'b0000} +: 16];
      b_p0 <= req_b[{grant_idx, 4'b0000} +: 16];
    end
  end

  assign prod_p0 = fp16_mul(a_p0, b_p0);

  generate
    if (PIPE_STAGES == 0) begin : g_direct
      logic shown_p0;

      // Output reads zero until the first product is produced after reset.
      always_ff @(posedge clk) begin
        if (!rst_n)      shown_p0 <= 1'b0;
        else if (vld_p0) shown_p0 <= 1'b1;
      end

      assign rsp_valid  = vld_p0;
      assign rsp_id     = id_p0;
      assign rsp_result = shown_p0 ? prod_p0 : 16'h0000;
      assign busy       = vld_p0;
    end else begin : g_pipe
      // Result stages p1..pN: data loads only with a valid op, so the last stage holds.
      logic [PIPE_STAGES-1:0] vld_pr;
      logic [ID_W-1:0]        id_pr  [PIPE_STAGES];
      logic [15:0]            res_pr [PIPE_STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_pr <= '0;
        end else begin
          vld_pr[0] <= vld_p0;
          for (int k = 1; k < PIPE_STAGES; k++) vld_pr[k] <= vld_pr[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (vld_p0) begin
          id_pr[0]  <= id_p0;
          res_pr[0] <= prod_p0;
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
          if (vld_pr[k-1]) begin
            id_pr[k]  <= id_pr[k-1];
            res_pr[k] <= res_pr[k-1];
          end
        end
        if (!rst_n) begin
          id_pr[PIPE_STAGES-1]  <= '0;
          res_pr[PIPE_STAGES-1] <= '0;
        end
      end

      assign rsp_valid  = vld_pr[PIPE_STAGES-1];
      assign rsp_id     = id_pr[PIPE_STAGES-1];
      assign rsp_result = res_pr[PIPE_STAGES-1];
      assign busy       = vld_p0 | (|vld_pr);
    end
  endgenerate

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter (NUM_REQ=4, PIPE_STAGES=2) with
// hand-computed FP16 products and immediate-assertion checks.
module tb_fp16_mul_arbiter;
  localparam int NR = 4;
  localparam int PS = 2;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*16-1:0] req_a = '0;
  logic [NR*16-1:0] req_b = '0;
  logic [NR-1:0]    req_ready;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [15:0]      rsp_result;
  logic             busy;
  logic [31:0]      op_count;

  int n_cmp = 0;
  int n_err = 0;

  fp16_mul_arbiter #(.NUM_REQ(NR), .PIPE_STAGES(PS), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (ok) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset: grants suppressed even with all requesters valid and en=1
    for (int i = 0; i < NR; i++) set_op(i, 16'h3C00, 16'h4000);
    en = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rst_ready", 32'(req_ready) === 32'(4'b0000), 32'(req_ready), 32'(4'b0000));
    tick();
    tick();
    chk("rst_ready2", 32'(req_ready) === 32'(4'b0000), 32'(req_ready), 32'(4'b0000));
    chk("rst_rsp_valid", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("rst_busy", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));
    chk("rst_op_count", op_count === 32'(0), op_count, 32'(0));
    chk("rst_result", 32'(rsp_result) === 32'(16'h0000), 32'(rsp_result), 32'(16'h0000));
    chk("rst_id", 32'(rsp_id) === 32'(2'd0), 32'(rsp_id), 32'(2'd0));
    req_valid = '0;
    rst_n = 1'b1;

    // Single op from requester 1: 1.0 * 2.0
    set_op(1, 16'h3C00, 16'h4000);
    req_valid = 4'b0010;
    #1;
    chk("t1_ready", 32'(req_ready) === 32'(4'b0010), 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    chk("t1_busy0", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    chk("t1_count", op_count === 32'(1), op_count, 32'(1));
    chk("t1_vld0", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    tick();
    chk("t1_busy1", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    chk("t1_vld1", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    tick();
    chk("t1_vld2", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
    chk("t1_id", 32'(rsp_id) === 32'(2'd1), 32'(rsp_id), 32'(2'd1));
    chk("t1_result", 32'(rsp_result) === 32'(16'h4000), 32'(rsp_result), 32'(16'h4000));
    chk("t1_busy2", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    tick();
    chk("t1_vld3", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("t1_busy3", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));
    chk("t1_hold", 32'(rsp_result) === 32'(16'h4000), 32'(rsp_result), 32'(16'h4000));

    // Reset returns ptr to 0 and clears the held result
    rst_n = 1'b0;
    tick();
    chk("t2_rst_result", 32'(rsp_result) === 32'(16'h0000), 32'(rsp_result), 32'(16'h0000));
    rst_n = 1'b1;

    // All four valid: 1.5*1.5 = 2.25 for each, granted 0,1,2,3
    for (int i = 0; i < NR; i++) set_op(i, 16'h3E00, 16'h3E00);
    req_valid = 4'hF;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_ready", 32'(req_ready) === 32'(4'b0001 << g), 32'(req_ready), 32'(4'b0001 << g));
      tick();
      req_valid[g] = 1'b0;
      if (g >= 2) begin
        chk("t2_vld", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
        chk("t2_id", 32'(rsp_id) === 32'(g - 2), 32'(rsp_id), 32'(g - 2));
        chk("t2_result", 32'(rsp_result) === 32'(16'h4080), 32'(rsp_result), 32'(16'h4080));
      end
    end
    for (int g = 2; g < 4; g++) begin
      tick();
      chk("t2_vld_tail", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
      chk("t2_id_tail", 32'(rsp_id) === 32'(g), 32'(rsp_id), 32'(g));
      chk("t2_result_tail", 32'(rsp_result) === 32'(16'h4080), 32'(rsp_result), 32'(16'h4080));
    end
    tick();
    chk("t2_vld_end", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("t2_busy_end", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));
    chk("t2_count", op_count === 32'(4), op_count, 32'(4));

    // Fairness: requesters 0 and 2 alternate; -2.0 * 3.0 = -6.0
    set_op(0, 16'h3C00, 16'h4000);
    set_op(2, 16'hC000, 16'h4200);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b0101 : 4'b0000;
      #1;
      if (c < 8)
        chk("t3_ready", 32'(req_ready) === 32'(((c % 2) == 0) ? 1 : 4),
            32'(req_ready), 32'(((c % 2) == 0) ? 1 : 4));
      tick();
      if (c >= 2) begin
        chk("t3_vld", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
        chk("t3_id", 32'(rsp_id) === 32'(((c % 2) == 0) ? 0 : 2),
            32'(rsp_id), 32'(((c % 2) == 0) ? 0 : 2));
        chk("t3_result", 32'(rsp_result) === 32'(((c % 2) == 0) ? 16'h4000 : 16'hC600),
            32'(rsp_result), 32'(((c % 2) == 0) ? 16'h4000 : 16'hC600));
      end
    end
    tick();
    chk("t3_vld_end", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("t3_count", op_count === 32'(12), op_count, 32'(12));

    // en toggle: ptr=3 so grants go 0,1, then en drops; resumes at 2
    for (int i = 0; i < 3; i++) set_op(i, 16'h3E00, 16'h3E00);
    req_valid = 4'b0111;
    #1;
    chk("t4_ready0", 32'(req_ready) === 32'(4'b0001), 32'(req_ready), 32'(4'b0001));
    tick();
    chk("t4_ready1", 32'(req_ready) === 32'(4'b0010), 32'(req_ready), 32'(4'b0010));
    tick();
    en = 1'b0;
    #1;
    chk("t4_ready_off", 32'(req_ready) === 32'(4'b0000), 32'(req_ready), 32'(4'b0000));
    tick();
    chk("t4_vld0", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
    chk("t4_id0", 32'(rsp_id) === 32'(2'd0), 32'(rsp_id), 32'(2'd0));
    chk("t4_busy0", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    tick();
    chk("t4_vld1", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
    chk("t4_id1", 32'(rsp_id) === 32'(2'd1), 32'(rsp_id), 32'(2'd1));
    chk("t4_result1", 32'(rsp_result) === 32'(16'h4080), 32'(rsp_result), 32'(16'h4080));
    chk("t4_busy1", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    tick();
    chk("t4_vld_off", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("t4_busy_off", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));
    chk("t4_count", op_count === 32'(14), op_count, 32'(14));
    en = 1'b1;
    #1;
    chk("t4_ready_resume", 32'(req_ready) === 32'(4'b0100), 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("t4_vld2", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
    chk("t4_id2", 32'(rsp_id) === 32'(2'd2), 32'(rsp_id), 32'(2'd2));
    chk("t4_result2", 32'(rsp_result) === 32'(16'h4080), 32'(rsp_result), 32'(16'h4080));
    tick();
    chk("t4_vld_end", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));

    // Reset mid-flight with two ops in the pipeline (ptr=3: grants 3 then 0)
    req_valid = 4'b1001;
    #1;
    chk("t5_ready3", 32'(req_ready) === 32'(4'b1000), 32'(req_ready), 32'(4'b1000));
    tick();
    req_valid = 4'b0001;
    #1;
    chk("t5_ready0", 32'(req_ready) === 32'(4'b0001), 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = '0;
    chk("t5_busy", 32'(busy) === 32'(1'b1), 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t5_rst_ready", 32'(req_ready) === 32'(4'b0000), 32'(req_ready), 32'(4'b0000));
    tick();
    chk("t5_vld", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    chk("t5_busy_rst", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));
    chk("t5_count", op_count === 32'(0), op_count, 32'(0));
    chk("t5_result", 32'(rsp_result) === 32'(16'h0000), 32'(rsp_result), 32'(16'h0000));
    chk("t5_id", 32'(rsp_id) === 32'(2'd0), 32'(rsp_id), 32'(2'd0));
    rst_n = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_rsp", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    end

    // Withdrawn request: requester 3 drops valid before its turn
    set_op(0, 16'h3C00, 16'h4000);
    set_op(3, 16'h3E00, 16'h3E00);
    req_valid = 4'b1001;
    #1;
    chk("t6_ready0", 32'(req_ready) === 32'(4'b0001), 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t6_ready_none", 32'(req_ready) === 32'(4'b0000), 32'(req_ready), 32'(4'b0000));
    tick();
    tick();
    chk("t6_vld", 32'(rsp_valid) === 32'(1'b1), 32'(rsp_valid), 32'(1'b1));
    chk("t6_id", 32'(rsp_id) === 32'(2'd0), 32'(rsp_id), 32'(2'd0));
    chk("t6_result", 32'(rsp_result) === 32'(16'h4000), 32'(rsp_result), 32'(16'h4000));
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("t6_no_id3", 32'(rsp_valid) === 32'(1'b0), 32'(rsp_valid), 32'(1'b0));
    end
    chk("t6_count", op_count === 32'(1), op_count, 32'(1));
    chk("t6_busy", 32'(busy) === 32'(1'b0), 32'(busy), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
